// File: rtl/axil_led_pkg.sv
// Shared constants for the AXI-Lite LED controller: register offsets, response codes,
// register-select decode and byte-strobe merge helper.
package axil_led_pkg;

    localparam logic [31:0] ID_DEFAULT = 32'h4C45_4430;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] OFF_ID           = 32'h00;
    localparam logic [31:0] OFF_SCRATCH      = 32'h04;
    localparam logic [31:0] OFF_LED_OUT      = 32'h08;
    localparam logic [31:0] OFF_BLINK_PERIOD = 32'h0C;
    localparam logic [31:0] OFF_BLINK_MASK   = 32'h10;
    localparam logic [31:0] OFF_CYCLE_CNT    = 32'h14;

    typedef enum logic [2:0] {
        SEL_ID,
        SEL_SCRATCH,
        SEL_LED_OUT,
        SEL_PERIOD,
        SEL_MASK,
        SEL_CYCLE,
        SEL_NONE
    } reg_sel_e;

    // Word decode; byte-lane bits [1:0] never take part.
    function automatic reg_sel_e decode(input logic [31:0] addr);
        case (addr[31:2])
            OFF_ID[31:2]:           return SEL_ID;
            OFF_SCRATCH[31:2]:      return SEL_SCRATCH;
            OFF_LED_OUT[31:2]:      return SEL_LED_OUT;
            OFF_BLINK_PERIOD[31:2]: return SEL_PERIOD;
            OFF_BLINK_MASK[31:2]:   return SEL_MASK;
            OFF_CYCLE_CNT[31:2]:    return SEL_CYCLE;
            default:                return SEL_NONE;
        endcase
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] wr,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wr[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axil_led_blink.sv
// Blink phase generator: phase toggles every `period` cycles; period 0 parks it low.
module axil_led_blink (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] period,
    input  logic        period_wr,
    output logic        phase
);

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (period_wr || period == 32'd0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt >= period - 32'd1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/axil_led_ctrl.sv
// AXI4-Lite LED/ID/scratch/cycle-count register slave with blink engine.
// Define AXIL_LED_SLVERR_EN to return SLVERR for unmapped accesses and RO writes.
module axil_led_ctrl
    import axil_led_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          NUM_LED    = 4,
    parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [NUM_LED-1:0]    led
);

    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;

    logic [31:0]           scratch, blink_period, cycle_cnt;
    logic [NUM_LED-1:0]    led_out, blink_mask;
    logic                  phase;

    reg_sel_e              wr_sel, rd_sel;
    logic                  wr_fire, wr_err, rd_err, period_wr;
    logic [31:0]           rd_data;
    logic                  unused;

    assign unused = ^{s_axil_awprot, s_axil_arprot};

    assign s_axil_awready = !aw_full && !s_axil_bvalid;
    assign s_axil_wready  = !w_full && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign wr_sel    = decode(32'(aw_addr));
    assign rd_sel    = decode(32'(s_axil_araddr));
    assign wr_fire   = aw_full && w_full && !s_axil_bvalid;
    assign period_wr = wr_fire && wr_sel == SEL_PERIOD;

`ifdef AXIL_LED_SLVERR_EN
    assign wr_err = wr_sel inside {SEL_ID, SEL_CYCLE, SEL_NONE};
    assign rd_err = rd_sel == SEL_NONE;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // Write channel holders, register file and B response.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            scratch       <= '0;
            blink_period  <= '0;
            led_out       <= '0;
            blink_mask    <= '0;
        end else begin
            if (s_axil_awvalid && s_axil_awready) begin
                aw_full <= 1'b1;
                aw_addr <= s_axil_awaddr;
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_full <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (wr_fire) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                case (wr_sel)
                    SEL_SCRATCH: scratch      <= apply_strb(scratch, w_data, w_strb);
                    SEL_PERIOD:  blink_period <= apply_strb(blink_period, w_data, w_strb);
                    SEL_LED_OUT: led_out      <= NUM_LED'(apply_strb(32'(led_out), w_data, w_strb));
                    SEL_MASK:    blink_mask   <= NUM_LED'(apply_strb(32'(blink_mask), w_data, w_strb));
                    default:     ;
                endcase
            end
            if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_ID:      rd_data = ID_VALUE;
            SEL_SCRATCH: rd_data = scratch;
            SEL_LED_OUT: rd_data = 32'(led_out);
            SEL_PERIOD:  rd_data = blink_period;
            SEL_MASK:    rd_data = 32'(blink_mask);
            SEL_CYCLE:   rd_data = cycle_cnt;
            default:     rd_data = '0;
        endcase
    end

    // Read data is captured at the AR handshake, so a same-cycle write is not yet visible.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_err ? 32'd0 : rd_data;
            s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) cycle_cnt <= '0;
        else              cycle_cnt <= cycle_cnt + 32'd1;
    end

    axil_led_blink u_blink (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .period    (blink_period),
        .period_wr (period_wr),
        .phase     (phase)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) led <= '0;
        else              led <= led_out ^ (blink_mask & {NUM_LED{phase}});
    end

endmodule

// File: tb/tb_axil_led_ctrl.sv
// Self-checking bench for axil_led_ctrl: vector table, corner sequences, randomized traffic vs a register model.
module tb_axil_led_ctrl;

    localparam int NL = 4;
    localparam logic [31:0] ID_EXP = 32'h4C45_4430;
    localparam logic [1:0]  OK = 2'b00;
`ifdef AXIL_LED_SLVERR_EN
    localparam logic [1:0]  ERR = 2'b10;
`else
    localparam logic [1:0]  ERR = 2'b00;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NL-1:0] led;

    axil_led_ctrl dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .led(led)
    );

    always #5 clk = ~clk;

    int cyc_now = 0;
    always @(posedge clk) cyc_now++;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register model: index = byte offset / 4
    logic [31:0] m [0:5];

    function automatic logic [31:0] impl_mask(input int i);
        if (i == 1 || i == 3) return 32'hFFFF_FFFF;
        if (i == 2 || i == 4) return (32'd1 << NL) - 32'd1;
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m[i] = 32'd0;
        m[0] = ID_EXP;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        logic [31:0] bm;
        i = int'(a >> 2);
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & impl_mask(i);
        if (i >= 1 && i <= 4) m[i] = (m[i] & ~bm) | (d & bm);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int bv_at, output int bv_cyc, output int hold_err);
        bit aw_done = 0, w_done = 0, b_done = 0, seen = 0;
        int c = 0;
        resp = 2'bxx; bv_at = -1; bv_cyc = 0; hold_err = 0;
        while (!b_done && c < 200) begin
            @(negedge clk);
            if (aw_done && awready) hold_err++;
            if (w_done && wready) hold_err++;
            if (seen && !bvalid) hold_err++;
            awvalid = !aw_done && c >= aw_dly; awaddr = addr;
            wvalid  = !w_done && c >= w_dly;   wdata = data; wstrb = strb;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            if (bvalid && !seen) begin seen = 1; bv_at = c; bv_cyc = cyc_now; end
            bready = seen && (c - bv_at) >= b_dly;
            if (bvalid && bready) begin b_done = 1; resp = bresp; end
            c++;
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0; bready = 0;
        if (!b_done) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %h got no B response, required one", addr);
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_dly, output logic [31:0] data,
                            output logic [1:0] resp, output int hs, output int rv_at, output int hold_err);
        bit ar_done = 0, r_done = 0, seen = 0;
        int c = 0;
        logic [31:0] first;
        first = '0; data = 'x; resp = 2'bxx; hs = 0; rv_at = -1; hold_err = 0;
        while (!r_done && c < 100) begin
            @(negedge clk);
            if (seen && (!rvalid || rdata !== first)) hold_err++;
            arvalid = !ar_done; araddr = addr;
            if (arvalid && arready) begin ar_done = 1; hs = cyc_now + 1; end
            if (rvalid && !seen) begin seen = 1; first = rdata; rv_at = c; end
            rready = seen && (c - rv_at) >= r_dly;
            if (rvalid && rready) begin r_done = 1; data = rdata; resp = rresp; end
            c++;
        end
        @(negedge clk);
        arvalid = 0; rready = 0;
        if (!r_done) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %h got no R response, required one", addr);
        end
    endtask

    typedef struct {
        logic [7:0]  wa; logic [31:0] wd; logic [3:0] ws; logic [1:0] eb;
        logic [7:0]  ra; logic [31:0] er; logic [1:0] err_r;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [1:0]  resp;
        logic [31:0] d, d2;
        int bv_at, bv_cyc, herr, hs, hs2, rv_at, k;

        tbl[0]  = '{8'h04, 32'hFFFF_FFFF, 4'hF, OK,  8'h04, 32'hFFFF_FFFF, OK};
        tbl[1]  = '{8'h04, 32'hA5A5_5A5A, 4'h2, OK,  8'h04, 32'hFFFF_5AFF, OK};
        tbl[2]  = '{8'h00, 32'h1234_5678, 4'hF, ERR, 8'h00, ID_EXP,        OK};
        tbl[3]  = '{8'h08, 32'hFFFF_FFFF, 4'hF, OK,  8'h08, 32'h0000_000F, OK};
        tbl[4]  = '{8'h10, 32'hFFFF_FFF0, 4'hF, OK,  8'h10, 32'h0000_0000, OK};
        tbl[5]  = '{8'h20, 32'hFFFF_FFFF, 4'hF, ERR, 8'h20, 32'h0000_0000, ERR};
        tbl[6]  = '{8'h14, 32'h0000_0000, 4'hF, ERR, 8'h07, 32'hFFFF_5AFF, OK};
        tbl[7]  = '{8'h0C, 32'hAB12_1234, 4'h3, OK,  8'h0E, 32'h0000_1234, OK};
        tbl[8]  = '{8'h0C, 32'hFFFF_FFFF, 4'h4, OK,  8'h0C, 32'h00FF_1234, OK};
        tbl[9]  = '{8'h08, 32'h0000_0000, 4'h1, OK,  8'h09, 32'h0000_0000, OK};
        tbl[10] = '{8'h40, 32'h5555_5555, 4'hF, ERR, 8'hFC, 32'h0000_0000, ERR};
        tbl[11] = '{8'h0C, 32'h0000_0000, 4'hF, OK,  8'h0C, 32'h0000_0000, OK};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_awready", awready, 1); chk("rst_wready", wready, 1); chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0); chk("rst_led", led, 0);
        chk("rst_rdata", rdata, 0);     chk("rst_bresp", bresp, 0);   chk("rst_rresp", rresp, 0);

        axi_read(8'h00, 0, d, resp, hs, rv_at, herr);
        chk("id_data", d, ID_EXP); chk("id_resp", resp, OK); chk("id_latency", rv_at, 1);
        chk("id_led", led, 0);

        // Vector table
        foreach (tbl[i]) begin
            axi_write(tbl[i].wa, tbl[i].wd, tbl[i].ws, 0, 0, 0, resp, bv_at, bv_cyc, herr);
            model_write(tbl[i].wa, tbl[i].wd, tbl[i].ws);
            chk($sformatf("vec%0d_bresp", i), resp, tbl[i].eb);
            chk($sformatf("vec%0d_blat", i), bv_at, 2);
            axi_read(tbl[i].ra, i % 3, d, resp, hs, rv_at, herr);
            chk($sformatf("vec%0d_rdata", i), d, tbl[i].er);
            chk($sformatf("vec%0d_rresp", i), resp, tbl[i].err_r);
            chk($sformatf("vec%0d_rhold", i), herr, 0);
        end

        // W three cycles ahead of AW, B held off for 5 cycles
        axi_write(8'h04, 32'h0BAD_F00D, 4'hF, 3, 0, 5, resp, bv_at, bv_cyc, herr);
        model_write(8'h04, 32'h0BAD_F00D, 4'hF);
        chk("wfirst_blat", bv_at, 5); chk("wfirst_hold", herr, 0); chk("wfirst_resp", resp, OK);
        chk("wfirst_awready_back", awready, 1); chk("wfirst_wready_back", wready, 1);
        axi_read(8'h04, 0, d, resp, hs, rv_at, herr);
        chk("wfirst_rdata", d, 32'h0BAD_F00D);

        // Blink engine
        axi_write(8'h08, 32'h1, 4'hF, 0, 0, 0, resp, bv_at, bv_cyc, herr);
        model_write(8'h08, 32'h1, 4'hF);
        axi_write(8'h10, 32'h3, 4'hF, 0, 0, 0, resp, bv_at, bv_cyc, herr);
        model_write(8'h10, 32'h3, 4'hF);
        axi_write(8'h0C, 32'd4, 4'hF, 0, 0, 0, resp, bv_at, bv_cyc, herr);
        model_write(8'h0C, 32'd4, 4'hF);
        for (int i = 0; i < 24; i++) begin
            k = cyc_now - bv_cyc;
            chk($sformatf("blink_k%0d", k), led, (((k - 1) / 4) % 2) ? 32'h2 : 32'h1);
            @(negedge clk);
        end
        axi_write(8'h0C, 32'd0, 4'hF, 0, 0, 0, resp, bv_at, bv_cyc, herr);
        model_write(8'h0C, 32'd0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blink_off%0d", i), led, 32'h1);
            @(negedge clk);
        end

        // Cycle counter advances exactly with handshake time
        axi_read(8'h14, 0, d, resp, hs, rv_at, herr);
        repeat (7) @(negedge clk);
        axi_read(8'h14, 2, d2, resp, hs2, rv_at, herr);
        chk("cycle_delta", d2 - d, 32'(hs2 - hs)); chk("cycle_resp", resp, OK);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            logic [31:0] wd;
            logic [3:0] ws;
            int idx, ad, wdl;
            idx = $urandom_range(0, 9);
            a = 8'(idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; ws = 4'($urandom_range(0, 15));
                ad = $urandom_range(0, 3); wdl = $urandom_range(0, 3);
                axi_write(a, wd, ws, ad, wdl, $urandom_range(0, 3), resp, bv_at, bv_cyc, herr);
                model_write(a, wd, ws);
                chk($sformatf("rnd%0d_bresp", n), resp, (idx >= 1 && idx <= 4) ? OK : ERR);
                chk($sformatf("rnd%0d_blat", n), bv_at, ((ad > wdl) ? ad : wdl) + 2);
                chk($sformatf("rnd%0d_bhold", n), herr, 0);
            end else begin
                axi_read(a, $urandom_range(0, 3), d, resp, hs, rv_at, herr);
                if (idx != 5) chk($sformatf("rnd%0d_rdata", n), d, (idx <= 4) ? m[idx] : 32'd0);
                chk($sformatf("rnd%0d_rresp", n), resp, (idx <= 5) ? OK : ERR);
                chk($sformatf("rnd%0d_rhold", n), herr, 0);
            end
        end

        // Reset while a B response is pending
        @(negedge clk);
        awaddr = 8'h08; awvalid = 1; wdata = 32'hF; wstrb = 4'hF; wvalid = 1; bready = 0;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 10 && !bvalid; i++) @(negedge clk);
        chk("rstmid_bvalid_pre", bvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_bvalid", bvalid, 0); chk("rstmid_led", led, 0); chk("rstmid_awready", awready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rstmid_no_b", bvalid, 0);
        axi_read(8'h04, 0, d, resp, hs, rv_at, herr);
        chk("rstmid_scratch", d, 0);
        axi_read(8'h08, 0, d, resp, hs, rv_at, herr);
        chk("rstmid_ledout", d, 0);
        axi_write(8'h04, 32'h1357_9BDF, 4'hF, 1, 0, 1, resp, bv_at, bv_cyc, herr);
        chk("rstmid_wresp", resp, OK); chk("rstmid_wlat", bv_at, 3);
        axi_read(8'h04, 0, d, resp, hs, rv_at, herr);
        chk("rstmid_readback", d, 32'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/axil_led_ctrl.md
# axil_led_ctrl

AXI4-Lite register slave that drives the board LEDs and exposes ID, scratch and free-running cycle-count registers to the host. It sits directly downstream of the PCIe DMA core's AXI-Lite master port, sharing that BAR with the AXI-Lite RAM or replacing it. An internal blink engine toggles selected LEDs at a host-programmed half-period.

## Interface
- `ADDR_WIDTH`, 8: byte-address bits decoded; upper bits are ignored.
- `NUM_LED`, 4: LED output count, 1..32.
- `ID_VALUE`, 32'h4C45_4430: value returned by the ID register.
- `axi_aclk` in 1: single clock for all logic.
- `axi_aresetn` in 1: asynchronous, active-low reset.
- `s_axil_awaddr` in ADDR_WIDTH; `s_axil_awprot` in 3 (ignored); `s_axil_awvalid` in 1; `s_axil_awready` out 1.
- `s_axil_wdata` in 32; `s_axil_wstrb` in 4; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
- `s_axil_bresp` out 2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
- `s_axil_araddr` in ADDR_WIDTH; `s_axil_arprot` in 3 (ignored); `s_axil_arvalid` in 1; `s_axil_arready` out 1.
- `s_axil_rdata` out 32; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
- `led` out NUM_LED: registered LED drive, 1 = on.

## Operation
- Register map (byte offset, addr[1:0] ignored):
  - 0x00 ID, RO.
  - 0x04 SCRATCH, RW, reset 0.
  - 0x08 LED_OUT, RW, bits [NUM_LED-1:0], reset 0.
  - 0x0C BLINK_PERIOD, RW, half-period in cycles, reset 0.
  - 0x10 BLINK_MASK, RW, bits [NUM_LED-1:0], reset 0.
  - 0x14 CYCLE_CNT, RO, free-running 32-bit, wraps 0xFFFF_FFFF→0.
- RW registers honour `wstrb` per byte; unimplemented bits read 0; writes to RO/unmapped offsets are discarded.
- Write path: AW and W are captured independently into one-entry holding registers, in either order.
  - `awready` is high only while the AW holder is empty and no B response is pending; `wready` likewise for the W holder.
  - Once both holders are full, the register is written and `bvalid` raised; both holders are released on the B handshake.
- Read path: `arready` is high while `rvalid` is low. On AR handshake the data is latched and `rvalid` raised; it is held stable until `rready`.
- Blink engine:
  - `cnt` counts 0..BLINK_PERIOD-1; on wrap, `phase` toggles.
  - BLINK_PERIOD = 0 holds `cnt` = 0 and `phase` = 0.
  - Any write to BLINK_PERIOD clears `cnt` and `phase`.
- LED output: `led` = LED_OUT ^ (BLINK_MASK & {NUM_LED{phase}}), registered.

## Timing
- Reset values: awready = 1, wready = 1, arready = 1, bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0, led = 0, all registers 0 except ID.
- Write: when AW and W are both accepted by edge E, the register update and `bvalid` = 1 are visible after E+1. With `bready` = 1, `bvalid` falls after E+2, and ready returns high in that same cycle.
- Read: AR accepted at edge E → `rvalid` and `rdata` valid after E+1. Back-to-back reads sustain one read every 2 cycles.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- CYCLE_CNT read returns its value at the AR-handshake edge.
- `led` follows a LED_OUT/BLINK_MASK write one cycle after the register update.
- Reset asserted mid-transaction aborts it silently. No response is issued after release.

## Configuration
- `AXIL_LED_SLVERR_EN` defined: reads or writes to unmapped offsets, and writes to RO registers, return resp = 2'b10 (SLVERR); read data is 0.
- Not defined: all accesses return OKAY (2'b00).

## Structure
- Package `axil_led_pkg` holds the register offset localparams, the default ID constant, and the RESP_OKAY/RESP_SLVERR codes.
- Sub-module `axil_led_blink` (inputs `period`, `period_wr`; output `phase`) contains `cnt` and `phase`. The top level holds the AXI-Lite FSMs and the register file.

## Test plan
- After reset, read 0x00 → rdata = 0x4C454430, rresp = OKAY, `led` = 0.
- Write 0x04 = 0xA5A5_5A5A with wstrb = 4'b0010, after a full write of 0xFFFF_FFFF → read back 0xFFFF_5AFF.
- W presented 3 cycles before AW, with `bready` low for 5 cycles → exactly one `bvalid`, held stable, and no second acceptance until the B handshake.
- LED_OUT = 0x1, BLINK_MASK = 0x3, BLINK_PERIOD = 4 → `led` alternates 0x1/0x2 every 4 cycles; writing BLINK_PERIOD = 0 returns `led` to 0x1.
- Read of 0x20 → rresp = SLVERR and rdata = 0 with `AXIL_LED_SLVERR_EN` defined, OKAY otherwise.
- Deassert `axi_aresetn` while `bvalid` is high → `bvalid` = 0 immediately (asynchronously), all registers cleared, and a new write completes normally after release.
